// File: rtl/queue_fill_controller.sv
// Packs a valid/ready word stream into 4-word write bursts and runs the circular queue pointers.
// Optional feature macro: QUEUE_PARTIAL_FLUSH_EN (adds in_last to flush a partial group).
module queue_fill_controller #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
`ifdef QUEUE_PARTIAL_FLUSH_EN
  input  logic              in_last,
`endif
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [ADDR_W-1:0] wr_addr1,
  output logic [ADDR_W-1:0] wr_addr2,
  output logic [ADDR_W-1:0] wr_addr3,
  output logic [DATA_W-1:0] wr_data0,
  output logic [DATA_W-1:0] wr_data1,
  output logic [DATA_W-1:0] wr_data2,
  output logic [DATA_W-1:0] wr_data3,
  input  logic              rd_req,
  output logic              rd_grant,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_LIMIT = (ADDR_W + 1)'(DEPTH - 4);
  localparam logic [ADDR_W:0] CNT_GROUP  = (ADDR_W + 1)'(4);
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] CNT_ZERO   = (ADDR_W + 1)'(0);

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t              state_r;
  logic [1:0]          idx_r;
  logic [DATA_W-1:0]   lane_r    [4];
  logic [ADDR_W-1:0]   head_r;
  logic [ADDR_W-1:0]   tail_r;
  logic [ADDR_W:0]     count_r;
  logic                wr_en_r;
  logic [ADDR_W-1:0]   wr_addr_r [4];
  logic [DATA_W-1:0]   wr_data_r [4];
  logic                rd_en_r;
  logic [ADDR_W-1:0]   rd_addr_r;

  logic                accept_s;
  logic                commit_s;
  logic                last_s;
  logic [ADDR_W:0]     count_next_s;

`ifdef QUEUE_PARTIAL_FLUSH_EN
  assign last_s = in_last;
`else
  assign last_s = 1'b0;
`endif

  assign in_ready = (state_r == FILL);
  assign full     = (count_r > FULL_LIMIT);
  assign empty    = (count_r == CNT_ZERO);
  assign rd_grant = rd_req & ~empty;
  assign accept_s = in_valid & in_ready;
  // full is judged on the current count, so a same-cycle read never enables a commit
  assign commit_s = (state_r == COMMIT) & ~full;
  assign count_next_s = count_r + (commit_s ? CNT_GROUP : CNT_ZERO) - (rd_grant ? CNT_ONE : CNT_ZERO);

  assign wr_en    = wr_en_r;
  assign wr_addr0 = wr_addr_r[0];
  assign wr_addr1 = wr_addr_r[1];
  assign wr_addr2 = wr_addr_r[2];
  assign wr_addr3 = wr_addr_r[3];
  assign wr_data0 = wr_data_r[0];
  assign wr_data1 = wr_data_r[1];
  assign wr_data2 = wr_data_r[2];
  assign wr_data3 = wr_data_r[3];
  assign rd_en    = rd_en_r;
  assign rd_addr  = rd_addr_r;
  assign count    = count_r;

  // Packing FSM, queue pointers and registered memory command outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= FILL;
      idx_r     <= 2'd0;
      head_r    <= {ADDR_W{1'b0}};
      tail_r    <= {ADDR_W{1'b0}};
      count_r   <= CNT_ZERO;
      wr_en_r   <= 1'b0;
      rd_en_r   <= 1'b0;
      rd_addr_r <= {ADDR_W{1'b0}};
      for (int j = 0; j < 4; j++) begin
        lane_r[j]    <= {DATA_W{1'b0}};
        wr_addr_r[j] <= {ADDR_W{1'b0}};
        wr_data_r[j] <= {DATA_W{1'b0}};
      end
    end else begin
      wr_en_r <= commit_s;
      rd_en_r <= rd_grant;
      count_r <= count_next_s;
      if (rd_grant) begin
        rd_addr_r <= head_r;
        head_r    <= head_r + ADDR_W'(1);
      end
      case (state_r)
        FILL: begin
          if (accept_s) begin
            lane_r[idx_r] <= in_data;
            // a flushed partial group is zero-padded in the lanes above the last word
            for (int j = 0; j < 4; j++) begin
              if (last_s && (j > int'(idx_r))) begin
                lane_r[j] <= {DATA_W{1'b0}};
              end
            end
            idx_r <= idx_r + 2'd1;
            if ((idx_r == 2'd3) || last_s) begin
              state_r <= COMMIT;
            end
          end
        end
        COMMIT: begin
          if (commit_s) begin
            for (int j = 0; j < 4; j++) begin
              wr_addr_r[j] <= tail_r + ADDR_W'(j);
              wr_data_r[j] <= lane_r[j];
            end
            tail_r  <= tail_r + ADDR_W'(4);
            idx_r   <= 2'd0;
            state_r <= FILL;
          end
        end
        default: begin
          state_r <= FILL;
          idx_r   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_queue_fill_controller.sv
// Self-checking bench for queue_fill_controller: directed scenarios plus randomized traffic
// against a queue-based reference model of the packing and queue rules.
module tb_queue_fill_controller;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = 32'h0;
  logic          rd_req = 1'b0;
`ifdef QUEUE_PARTIAL_FLUSH_EN
  logic          in_last = 1'b0;
`endif
  logic          in_ready, wr_en, rd_grant, rd_en, full, empty;
  logic [AW-1:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3, rd_addr;
  logic [DW-1:0] wr_data0, wr_data1, wr_data2, wr_data3;
  logic [AW:0]   count;

  queue_fill_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data),
`ifdef QUEUE_PARTIAL_FLUSH_EN
    .in_last(in_last),
`endif
    .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_addr3(wr_addr3),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_data2(wr_data2), .wr_data3(wr_data3),
    .rd_req(rd_req), .rd_grant(rd_grant), .rd_en(rd_en), .rd_addr(rd_addr),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            m_cnt, m_head, m_tail;
  logic [31:0]   pend[$];
  logic [31:0]   ref_q[$];
  logic [31:0]   mem_m [DEPTH];
  logic          exp_wr_en, exp_rd_en, last_acc;
  logic [19:0]   exp_wr_addr_cat;
  logic [127:0]  exp_wr_data_cat;
  int            exp_rd_addr;
  logic [31:0]   exp_rd_word;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] addr_cat(input int t);
    logic [19:0] r = 20'h0;
    for (int k = 0; k < 4; k++) r = {r[14:0], 5'((t + k) % DEPTH)};
    return r;
  endfunction

  // One clock: drive inputs, compare DUT against the model, then advance the model.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic lst);
    int sz;
    logic acc, cmt, gnt;
    @(negedge clk);
    in_valid = v; in_data = d; rd_req = r;
`ifdef QUEUE_PARTIAL_FLUSH_EN
    in_last = lst;
`endif
    #1;
    sz = pend.size();
    chk("in_ready", in_ready, sz < 4);
    chk("count", count, m_cnt);
    chk("full", full, m_cnt > DEPTH - 4);
    chk("empty", empty, m_cnt == 0);
    chk("rd_grant", rd_grant, r && (m_cnt > 0));
    chk("wr_en", wr_en, exp_wr_en);
    if (exp_wr_en) begin
      chk("wr_addr", {wr_addr0, wr_addr1, wr_addr2, wr_addr3}, exp_wr_addr_cat);
      chk("wr_data", {wr_data0, wr_data1, wr_data2, wr_data3}, exp_wr_data_cat);
      mem_m[wr_addr0] = wr_data0; mem_m[wr_addr1] = wr_data1;
      mem_m[wr_addr2] = wr_data2; mem_m[wr_addr3] = wr_data3;
    end
    chk("rd_en", rd_en, exp_rd_en);
    if (exp_rd_en) begin
      chk("rd_addr", rd_addr, exp_rd_addr);
      chk("rd_word", mem_m[exp_rd_addr], exp_rd_word);
    end
    acc = v && (sz < 4);
    cmt = (sz == 4) && !(m_cnt > DEPTH - 4);
    gnt = r && (m_cnt > 0);
    exp_wr_en = cmt;
    if (cmt) begin
      exp_wr_addr_cat = addr_cat(m_tail);
      exp_wr_data_cat = {pend[0], pend[1], pend[2], pend[3]};
      for (int k = 0; k < 4; k++) ref_q.push_back(pend[k]);
      pend.delete();
      m_tail = (m_tail + 4) % DEPTH;
    end
    if (acc) begin
      pend.push_back(d);
`ifdef QUEUE_PARTIAL_FLUSH_EN
      if (lst) while (pend.size() < 4) pend.push_back(32'h0);
`endif
    end
    exp_rd_en = gnt;
    if (gnt) begin
      exp_rd_addr = m_head;
      exp_rd_word = ref_q.pop_front();
      m_head = (m_head + 1) % DEPTH;
    end
    m_cnt = m_cnt + (cmt ? 4 : 0) - (gnt ? 1 : 0);
    last_acc = acc;
    @(posedge clk);
  endtask

  task automatic push(input logic [31:0] d, input logic lst);
    int n = 0;
    do begin
      step(1'b1, d, 1'b0, lst);
      n++;
    end while (!last_acc && n < 100);
    chk("push_accept", last_acc, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; rd_req = 1'b0;
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_count", count, 6'd0);
    chk("rst_rd_addr", rd_addr, 5'd0);
    chk("rst_wr_addr", {wr_addr0, wr_addr1, wr_addr2, wr_addr3}, 20'h0);
    chk("rst_wr_data", {wr_data0, wr_data1, wr_data2, wr_data3}, 128'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    pend.delete(); ref_q.delete();
    m_cnt = 0; m_head = 0; m_tail = 0;
    exp_wr_en = 1'b0; exp_rd_en = 1'b0; last_acc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int wbias, rbias;

    // Basic group of four
    do_reset();
    push(32'h11, 1'b0); push(32'h22, 1'b0); push(32'h33, 1'b0); push(32'h44, 1'b0);
    #1 chk("t1_ready_low", in_ready, 1'b0);
    idle(1);
    #1;
    chk("t1_wr_en", wr_en, 1'b1);
    chk("t1_wr_addr", {wr_addr0, wr_addr1, wr_addr2, wr_addr3}, {5'd0, 5'd1, 5'd2, 5'd3});
    chk("t1_wr_data", {wr_data0, wr_data1, wr_data2, wr_data3}, {32'h11, 32'h22, 32'h33, 32'h44});
    chk("t1_count", count, 6'd4);
    chk("t1_ready_back", in_ready, 1'b1);

    // Fill to 32, hold a fifth group until reads free space, wrap to address 0
    do_reset();
    for (int i = 0; i < 32; i++) push(32'h100 + 32'(i), 1'b0);
    idle(1);
    for (int i = 32; i < 36; i++) push(32'h100 + 32'(i), 1'b0);
    idle(3);
    #1;
    chk("t2_full", full, 1'b1);
    chk("t2_count", count, 6'd32);
    chk("t2_held", in_ready, 1'b0);
    chk("t2_no_wr", wr_en, 1'b0);
    rd();
    #1;
    chk("t2_rd_en", rd_en, 1'b1);
    chk("t2_rd_addr", rd_addr, 5'd0);
    chk("t2_count31", count, 6'd31);
    chk("t2_still_full", full, 1'b1);
    rd(); rd(); rd();
    idle(1);
    #1;
    chk("t2_wrap_wr_en", wr_en, 1'b1);
    chk("t2_wrap_addr", {wr_addr0, wr_addr1, wr_addr2, wr_addr3}, {5'd0, 5'd1, 5'd2, 5'd3});
    chk("t2_wrap_data", {wr_data0, wr_data1, wr_data2, wr_data3}, {32'h120, 32'h121, 32'h122, 32'h123});
    chk("t2_count32", count, 6'd32);

    // Read while empty, then drain one group
    do_reset();
    rd();
    #1 chk("t3_empty_rd_en", rd_en, 1'b0);
    push(32'hB0, 1'b0); push(32'hB1, 1'b0); push(32'hB2, 1'b0); push(32'hB3, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      rd();
      #1 chk("t3_rd_addr", rd_addr, 5'(i));
    end
    chk("t3_empty", empty, 1'b1);

    // Commit and read in the same cycle at count 8
    do_reset();
    for (int i = 0; i < 12; i++) push(32'hC00 + 32'(i), 1'b0);
    #1 chk("t4_count8", count, 6'd8);
    rd();
    #1;
    chk("t4_count11", count, 6'd11);
    chk("t4_rd_addr0", rd_addr, 5'd0);
    chk("t4_wr_addr8", {wr_addr0, wr_addr1, wr_addr2, wr_addr3}, {5'd8, 5'd9, 5'd10, 5'd11});
    rd();
    #1 chk("t4_head1", rd_addr, 5'd1);

    // Reset mid-group discards the partial words
    do_reset();
    push(32'hDEAD0, 1'b0); push(32'hDEAD1, 1'b0);
    do_reset();
    push(32'hE0, 1'b0); push(32'hE1, 1'b0); push(32'hE2, 1'b0); push(32'hE3, 1'b0);
    idle(1);
    #1;
    chk("t5_addr", {wr_addr0, wr_addr1, wr_addr2, wr_addr3}, {5'd0, 5'd1, 5'd2, 5'd3});
    chk("t5_data", {wr_data0, wr_data1, wr_data2, wr_data3}, {32'hE0, 32'hE1, 32'hE2, 32'hE3});

`ifdef QUEUE_PARTIAL_FLUSH_EN
    // Partial group flushed by in_last
    do_reset();
    push(32'hA1, 1'b0); push(32'hA2, 1'b1);
    idle(1);
    #1;
    chk("t6_flush_data", {wr_data0, wr_data1, wr_data2, wr_data3}, {32'hA1, 32'hA2, 32'h0, 32'h0});
    chk("t6_flush_count", count, 6'd4);
`endif

    // Randomized traffic with phases that bias toward filling or draining
    do_reset();
    wbias = 70; rbias = 40;
    for (int c = 0; c < 2000; c++) begin
      if (c % 150 == 0) begin
        wbias = int'($urandom_range(20, 95));
        rbias = int'($urandom_range(5, 80));
      end
      step(int'($urandom_range(0, 99)) < wbias, $urandom,
           int'($urandom_range(0, 99)) < rbias, $urandom_range(0, 99) < 10);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/queue_fill_controller.md
Name: queue_fill_controller

Overview:
- Sits directly upstream of the team's 4-write/1-read queue memory (32-bit words, 5-bit addresses).
- Accepts a valid/ready stream of 32-bit words and packs them in groups of 4.
- Commits each full group as one 4-address write burst on memory port A and runs a circular queue (tail/head/count).
- Turns consumer read requests into single-word port-B read commands.

Parameters:
- ADDR_W, 5, memory address width; queue depth DEPTH = 2**ADDR_W words; ADDR_W >= 2 required.
- DATA_W, 32, word width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_data  in  DATA_W  input word.
- in_ready  out  1  block can accept a word this cycle.
- wr_en  out  1  one-cycle write-burst strobe to memory port A.
- wr_addr0..wr_addr3  out  ADDR_W each  burst addresses (tail, tail+1, tail+2, tail+3 mod DEPTH).
- wr_data0..wr_data3  out  DATA_W each  packed words, lane 0 = oldest.
- rd_req  in  1  consumer requests one word.
- rd_grant  out  1  combinational: rd_req & !empty.
- rd_en  out  1  registered read strobe to memory port B.
- rd_addr  out  ADDR_W  registered read address.
- count  out  ADDR_W+1  committed words in queue, 0..DEPTH.
- full  out  1  count > DEPTH-4 (no room for a group).
- empty  out  1  count == 0.

Behaviour:
- Reset (async, rst_n low): state FILL, lane index 0, head = tail = 0, count = 0; all wr_*/rd_* outputs 0; in_ready = 1 after release; partial group discarded, even mid-burst.
- Packing: a word is accepted when in_valid & in_ready. Lane[idx] <= in_data, idx++. The 4th accept (idx 3) moves FILL -> COMMIT.
- in_ready = (state == FILL).
- COMMIT:
  - If !full: next edge registers wr_en = 1, wr_addrN = tail+N (mod DEPTH, wrap 31 -> 0 at ADDR_W = 5) and wr_dataN = lane N. Then tail += 4, count += 4, idx = 0, state FILL.
  - If full: stay in COMMIT, wr_en = 0, in_ready = 0, until a read frees space.
- wr_en is high for exactly one cycle per group. The word accepted on cycle N (4th) is in memory after edge N+2.
- Read:
  - rd_grant = rd_req & !empty.
  - On grant, next edge: rd_en = 1, rd_addr = head, head += 1 (mod DEPTH), count -= 1.
  - Memory data is valid one cycle after rd_en (memory out_valid).
  - rd_req while empty: ignored; rd_en = 0, no pointer change.
- Simultaneous commit and read in one cycle: count_next = count + 4 - 1. full is evaluated on the current count, so a commit is not enabled by a same-cycle read.
- Only committed words are readable; read and write addresses never overlap within a cycle.
- Ports A/B never see write and read on the same port.
- count saturates logically at DEPTH (guaranteed by full). No underflow (guaranteed by empty).

Optional Feature:
- Macro QUEUE_PARTIAL_FLUSH_EN.
- Defined:
  - Extra input port in_last (1 bit).
  - Accepting a word with in_last = 1 forces COMMIT with lanes idx+1..3 filled with zero.
  - A group is always 4 words; a last word in lane 3 behaves as normal.
- Undefined:
  - Port in_last is absent.
  - Only complete 4-word groups are committed; a partial group waits indefinitely for more input.

Test Plan:
- Reset, push 0x11,0x22,0x33,0x44 back-to-back -> one wr_en pulse with addr 0,1,2,3, data 0x11..0x44; count = 4; in_ready low 1 cycle.
- 8 groups (32 words) with no reads -> count = 32, full = 1. 33rd..36th words accepted, then held in COMMIT with in_ready = 0. One rd_req -> rd_addr 0, count 31, still full. Four reads -> group commits to addr 0..3 (wrap), count = 32.
- rd_req with count = 0 -> rd_grant = 0, rd_en = 0, head unchanged. After 4 words commit, 4 reads -> rd_addr 0,1,2,3, empty = 1.
- Commit and rd_grant in the same cycle at count = 8 -> count = 11 next cycle, head = 1, tail = 12.
- rst_n asserted after 2 of 4 words -> outputs 0, count 0. Next 4 words write to addr 0..3 with the new data only.
- QUEUE_PARTIAL_FLUSH_EN: push 0xA1, 0xA2 with in_last on 0xA2 -> wr_data = 0xA1, 0xA2, 0, 0; count = 4.
